// File: rtl/action_dispatcher.sv
// action_dispatcher
//   Turns click/move codes from a pointing source into cursor updates and
//   board-operation requests (reveal / flag toggle), one code at a time.
//   Each consumed code gets a single-cycle ACK. A code that is held is only
//   dispatched once: after the ACK the block waits for Action=000.
//
// Ports
//   clk         in   single clock, rising edge
//   clear_n     in   asynchronous active-low reset
//   Action      in   3  click code (000 none, 001 click, 010 double, 011 rsvd,
//                      100 U, 101 R, 110 D, 111 L)
//   ACK         out  1  code consumed (one-cycle pulse)
//   cursor_row  out  4  cursor row, 0..ROWS-1
//   cursor_col  out  4  cursor column, 0..COLS-1
//   req_valid   out  1  board request pending
//   req_op      out  2  01 reveal, 10 flag toggle, 00 when idle
//   req_row     out  4  request row
//   req_col     out  4  request column
//   req_ready   in   1  board accepts request when req_valid & req_ready
//   busy        out  1  high in every state except IDLE
//
// Build option
//   CURSOR_WRAP_EN  defined: cursor wraps around board edges;
//                   undefined: cursor saturates at the edges.
//
// state    | meaning
// IDLE     | waiting for a code
// ISSUE    | board request presented, waiting for req_ready
// ACKP     | ACK pulse
// WAIT_CLR | waiting for Action=000 so a held code is not re-dispatched
module action_dispatcher #(
  parameter int ROWS = 10,
  parameter int COLS = 10
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [2:0] Action,
  output logic       ACK,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       req_valid,
  output logic [1:0] req_op,
  output logic [3:0] req_row,
  output logic [3:0] req_col,
  input  logic       req_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACKP, WAIT_CLR} state_t;

  localparam logic [2:0] A_NONE  = 3'b000;
  localparam logic [2:0] A_CLICK = 3'b001;
  localparam logic [2:0] A_DBL   = 3'b010;
  localparam logic [2:0] A_RSVD  = 3'b011;
  localparam logic [2:0] A_U     = 3'b100;
  localparam logic [2:0] A_R     = 3'b101;
  localparam logic [2:0] A_D     = 3'b110;
  localparam logic [2:0] A_L     = 3'b111;

  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);

  // Value the cursor takes when a move would leave the board.
`ifdef CURSOR_WRAP_EN
  localparam logic [3:0] ROW_BELOW_0   = ROW_MAX;
  localparam logic [3:0] ROW_ABOVE_MAX = 4'd0;
  localparam logic [3:0] COL_BELOW_0   = COL_MAX;
  localparam logic [3:0] COL_ABOVE_MAX = 4'd0;
`else
  localparam logic [3:0] ROW_BELOW_0   = 4'd0;
  localparam logic [3:0] ROW_ABOVE_MAX = ROW_MAX;
  localparam logic [3:0] COL_BELOW_0   = 4'd0;
  localparam logic [3:0] COL_ABOVE_MAX = COL_MAX;
`endif

  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] req_row_q, req_row_d;
  logic [3:0] req_col_q, req_col_d;
  logic [1:0] req_op_q, req_op_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      req_row_q <= 4'd0;
      req_col_q <= 4'd0;
      req_op_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      req_row_q <= req_row_d;
      req_col_q <= req_col_d;
      req_op_q  <= req_op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    req_row_d = req_row_q;
    req_col_d = req_col_q;
    req_op_d  = req_op_q;
    case (state_q)
      IDLE: begin
        case (Action)
          A_U: begin
            row_d   = (row_q == 4'd0) ? ROW_BELOW_0 : row_q - 4'd1;
            state_d = ACKP;
          end
          A_D: begin
            row_d   = (row_q >= ROW_MAX) ? ROW_ABOVE_MAX : row_q + 4'd1;
            state_d = ACKP;
          end
          A_L: begin
            col_d   = (col_q == 4'd0) ? COL_BELOW_0 : col_q - 4'd1;
            state_d = ACKP;
          end
          A_R: begin
            col_d   = (col_q >= COL_MAX) ? COL_ABOVE_MAX : col_q + 4'd1;
            state_d = ACKP;
          end
          A_CLICK, A_DBL: begin
            req_row_d = row_q;
            req_col_d = col_q;
            req_op_d  = (Action == A_CLICK) ? 2'b01 : 2'b10;
            state_d   = ISSUE;
          end
          A_RSVD:  state_d = ACKP;
          A_NONE:  state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
      ISSUE: begin
        if (req_ready) begin
          req_op_d = 2'b00;
          state_d  = ACKP;
        end
      end
      ACKP:     state_d = WAIT_CLR;
      WAIT_CLR: if (Action == A_NONE) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign ACK        = (state_q == ACKP);
  assign req_valid  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign req_op     = req_op_q;
  assign req_row    = req_row_q;
  assign req_col    = req_col_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_action_dispatcher.sv
module tb_action_dispatcher;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [2:0] Action;
  logic       ACK;
  logic [3:0] cursor_row, cursor_col;
  logic       req_valid;
  logic [1:0] req_op;
  logic [3:0] req_row, req_col;
  logic       req_ready;
  logic       busy;

  action_dispatcher #(.ROWS(10), .COLS(10)) dut (
    .clk(clk), .clear_n(clear_n), .Action(Action), .ACK(ACK),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .req_valid(req_valid), .req_op(req_op), .req_row(req_row),
    .req_col(req_col), .req_ready(req_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_req;
    logic [1:0] op;
    logic [3:0] r;
    logic [3:0] c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push_ack(input logic [3:0] r, input logic [3:0] c);
    exp_t e;
    e.is_req = 1'b0; e.op = 2'b00; e.r = r; e.c = c;
    q.push_back(e);
  endtask

  task automatic push_req(input logic [1:0] op, input logic [3:0] r, input logic [3:0] c);
    exp_t e;
    e.is_req = 1'b1; e.op = op; e.r = r; e.c = c;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full move/reserved dispatch: code sampled, ACKP, WAIT_CLR sees 000, IDLE.
  task automatic dispatch_ack_only(input logic [2:0] code, input string name);
    Action = code;
    step();
    chk({name, "_no_req"}, req_valid, 0);
    Action = 3'b000;
    step();
    step();
    chk({name, "_busy_end"}, busy, 0);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    #3;
    clear_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each handshake and each ACK.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("ack_and_valid_exclusive", ACK & req_valid, 0);
      if (!req_valid) chk("req_op_zero_when_idle", req_op, 0);
      if (req_valid && req_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request: got op %0h expected none", req_op);
        end else begin
          e = q.pop_front();
          chk("req_kind", 1, e.is_req);
          chk("req_op", req_op, e.op);
          chk("req_row", req_row, e.r);
          chk("req_col", req_col, e.c);
        end
      end
      if (ACK) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ACK=1 expected none");
        end else begin
          e = q.pop_front();
          chk("ack_kind", 0, e.is_req);
          chk("ack_cursor_row", cursor_row, e.r);
          chk("ack_cursor_col", cursor_col, e.c);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    clear_n   = 1'b0;
    Action    = 3'b000;
    req_ready = 1'b0;
    #12;
    chk("rst_ack", ACK, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_op", req_op, 0);
    chk("rst_req_row", req_row, 0);
    chk("rst_req_col", req_col, 0);
    chk("rst_cursor_row", cursor_row, 0);
    chk("rst_cursor_col", cursor_col, 0);
    chk("rst_busy", busy, 0);
    clear_n = 1'b1;
    mon_en  = 1'b1;
    step();

    // R held for three sampling edges, then released.
    push_ack(4'd0, 4'd1);
    Action = 3'b101;
    step();
    chk("move_col_on_edge", cursor_col, 1);
    step();
    step();
    chk("held_busy", busy, 1);
    Action = 3'b000;
    step();
    chk("held_busy_released", busy, 0);
    chk("held_single_move", cursor_col, 1);

    // Walk to (2,3).
    push_ack(4'd1, 4'd1); dispatch_ack_only(3'b110, "mv_d1");
    push_ack(4'd2, 4'd1); dispatch_ack_only(3'b110, "mv_d2");
    push_ack(4'd2, 4'd2); dispatch_ack_only(3'b101, "mv_r1");
    push_ack(4'd2, 4'd3); dispatch_ack_only(3'b101, "mv_r2");

    // Reveal with req_ready low for 4 cycles; Action changes ignored.
    push_req(2'b01, 4'd2, 4'd3);
    push_ack(4'd2, 4'd3);
    Action = 3'b001;
    step();
    Action = 3'b111;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid) vcnt++;
      step();
    end
    Action    = 3'b000;
    req_ready = 1'b1;
    if (req_valid) vcnt++;
    step();
    req_ready = 1'b0;
    chk("reveal_valid_cycles", vcnt, 5);
    chk("reveal_valid_dropped", req_valid, 0);
    chk("reveal_ack_after_hs", ACK, 1);
    step();
    step();
    chk("reveal_cursor_frozen_row", cursor_row, 2);
    chk("reveal_cursor_frozen_col", cursor_col, 3);
    chk("reveal_idle", busy, 0);

    // Flag with req_ready already high.
    push_req(2'b10, 4'd2, 4'd3);
    push_ack(4'd2, 4'd3);
    req_ready = 1'b1;
    Action    = 3'b010;
    step();
    chk("flag_valid", req_valid, 1);
    chk("flag_op", req_op, 2);
    Action = 3'b000;
    step();
    chk("flag_valid_one_cycle", req_valid, 0);
    chk("flag_ack", ACK, 1);
    req_ready = 1'b0;
    step();
    step();

    // Reserved code: ACK only.
    push_ack(4'd2, 4'd3);
    dispatch_ack_only(3'b011, "rsvd");

    // Edges from (0,0).
    do_reset();
    step();
    push_ack(WRAP ? 4'd9 : 4'd0, 4'd0);
    dispatch_ack_only(3'b100, "edge_u");
    push_ack(WRAP ? 4'd9 : 4'd0, WRAP ? 4'd9 : 4'd0);
    dispatch_ack_only(3'b111, "edge_l");
    push_ack(WRAP ? 4'd0 : 4'd1, WRAP ? 4'd9 : 4'd0);
    dispatch_ack_only(3'b110, "edge_d");
    push_ack(WRAP ? 4'd0 : 4'd1, WRAP ? 4'd0 : 4'd1);
    dispatch_ack_only(3'b101, "edge_r");

    // Reset while a request is pending: no ACK may follow.
    Action = 3'b001;
    step();
    chk("abort_valid_before", req_valid, 1);
    Action = 3'b000;
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort_valid_async", req_valid, 0);
    chk("abort_cursor_row", cursor_row, 0);
    chk("abort_cursor_col", cursor_col, 0);
    chk("abort_ack", ACK, 0);
    step();
    step();
    clear_n = 1'b1;
    // First edge after reset samples normally.
    push_ack(4'd0, 4'd1);
    dispatch_ack_only(3'b101, "post_rst_r");
    step();
    step();
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
